obj_ram_arbiter: RTL and testbench
==================================

Name: obj_ram_arbiter

Overview:
- Shares the single-port 32x8 object RAM between two requesters.
  - Port 0: layer renderer, read-only; fetches 8 object bytes per frame.
  - Port 1: game-logic engine, read/write; updates paddle and ball positions.
- Issues at most one RAM access per cycle and returns read data in order, tagged to the requester.
- Gives port 0 fixed priority, bounded by a starvation guard so port 1 always makes progress.

Parameters:
- RD_LAT, 2, cycles from address issue to i_ram_rdata valid (address register plus RAM output register).
- MAX_WAIT, 8, cycles port 1 may wait with a pending request before it is forced a grant.
- AW, 5, RAM address width.
- DW, 8, RAM data width.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_req0  in  1  port 0 read request, held until granted
- i_addr0  in  AW  port 0 address
- i_lock0  in  1  port 0 burst lock: keep ownership while asserted with i_req0
- o_gnt0  out  1  port 0 access accepted this cycle
- o_rvalid0  out  1  o_rdata0 valid
- o_rdata0  out  DW  port 0 read data
- i_req1  in  1  port 1 request, held until granted
- i_we1  in  1  port 1 write (1) / read (0)
- i_addr1  in  AW  port 1 address
- i_wdata1  in  DW  port 1 write data
- o_gnt1  out  1  port 1 access accepted this cycle
- o_rvalid1  out  1  o_rdata1 valid
- o_rdata1  out  DW  port 1 read data
- o_ram_address  out  AW  RAM address (registered)
- o_ram_we  out  1  RAM write enable (registered)
- o_ram_wdata  out  DW  RAM write data (registered)
- i_ram_rdata  in  DW  RAM read data
- o_busy  out  1  any access in flight or ownership held

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0; tag pipeline cleared. Asserting reset mid-burst drops in-flight reads; no rvalid is produced for them.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt high at a clock edge.
  - gnt is combinational from current state and requests. It is high for exactly the cycle the access is accepted.
  - A requester may present its next access in the cycle after gnt. Back-to-back grants to one port give 1 access per cycle.
- Issue: on gnt, the accepted port's address/we/wdata are registered into o_ram_* at the same edge. With no grant, o_ram_we is 0 and the address holds.
- Read return:
  - A read accepted at edge N gives rvalid on that port during cycle N+RD_LAT, with rdata = i_ram_rdata.
  - Writes produce no rvalid.
  - Tracking uses an RD_LAT-deep shift register of {valid, port}.
- State machine:
  - IDLE:
    - Both requesting and wait counter == MAX_WAIT: grant 1.
    - Otherwise both requesting: grant 0.
    - Single requester: grant it.
    - After a grant, go to OWNn if the granted port's lock is high, else stay IDLE.
  - OWN0: only port 0 can be granted. Return to IDLE when i_lock0 is low or i_req0 is low at a cycle boundary.
  - OWN1: same rule for port 1. Port 1 lock is implied by holding i_req1 continuously for at most MAX_WAIT beats.
  - Starvation guard overrides OWN0: when the counter hits MAX_WAIT, the next cycle grants port 1 once, then returns to OWN0 if i_lock0 is still high.
- Wait counter:
  - Increments each cycle i_req1 is high without o_gnt1, saturating at MAX_WAIT.
  - Clears on o_gnt1 or when i_req1 is low.
- No read-during-write hazard: single port, one access per cycle. Order is strictly issue order.
- o_busy = state != IDLE or any tag valid.

Decomposition:
- Shared package holds:
  - State encodings IDLE/OWN0/OWN1.
  - Port ID constants P_RENDER = 0, P_LOGIC = 1.
  - Object RAM map: P1_X = 0, P1_Y = 1, P1_H = 2, P2_X = 3, P2_Y = 4, P2_H = 5, BALL_X = 6, BALL_Y = 7.
- One natural sub-module: rd_tag_pipe, the RD_LAT-deep valid/port shift register with demux of i_ram_rdata to the two rdata/rvalid outputs.

Test Plan:
- Port 0 alone reads addr 0..7 with i_lock0 high, RAM preloaded 1,10,20,117,15,25,50,30 -> gnt0 on 8 consecutive cycles; rvalid0 2 cycles after each gnt, rdata0 in the same order; state OWN0 throughout, then IDLE.
- Port 1 writes addr 6 = 0x33, then reads addr 6 -> gnt1 on two consecutive cycles; o_ram_we = 1 for the first beat only; rvalid1 with 0x33 two cycles after the read grant.
- Both request simultaneously, no locks -> gnt0 first; port 1 granted the cycle port 0 drops req.
- Port 0 locked 20-beat burst with i_req1 held from beat 0 -> gnt1 occurs exactly once after 8 waiting cycles; port 0 resumes next cycle; both read streams return correct tagged data.
- Reset asserted with two reads in flight -> all outputs 0 asynchronously; no rvalid after release; first post-reset grant behaves as from IDLE.
- Port 1 read accepted the cycle after a port 0 read -> rvalid0 then rvalid1 on consecutive cycles; no cross-port data swap.

Source files
------------

// File: rtl/obj_ram_arbiter_pkg.sv
// Shared types and constants for the object RAM arbiter and its read-tag pipe.
package obj_ram_arbiter_pkg;

   localparam int DEF_AW       = 5;
   localparam int DEF_DW       = 8;
   localparam int DEF_RD_LAT   = 2;
   localparam int DEF_MAX_WAIT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   localparam logic P_RENDER = 1'b0;
   localparam logic P_LOGIC  = 1'b1;

   // Object RAM map
   localparam logic [4:0] P1_X   = 5'd0;
   localparam logic [4:0] P1_Y   = 5'd1;
   localparam logic [4:0] P1_H   = 5'd2;
   localparam logic [4:0] P2_X   = 5'd3;
   localparam logic [4:0] P2_Y   = 5'd4;
   localparam logic [4:0] P2_H   = 5'd5;
   localparam logic [4:0] BALL_X = 5'd6;
   localparam logic [4:0] BALL_Y = 5'd7;

   typedef struct packed {
      logic valid;
      logic port;
   } rd_tag_t;

   function automatic logic tag_is_port(input rd_tag_t t, input logic p);
      return t.valid && (t.port == p);
   endfunction

endpackage

// File: rtl/obj_ram_arbiter_rd_tag_pipe.sv
// Tracks outstanding reads as {valid, port} tags and steers the returning RAM
// data to the requester that issued the read.
module obj_ram_arbiter_rd_tag_pipe
   import obj_ram_arbiter_pkg::*;
#(
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int DW     = DEF_DW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_port,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_any_valid,
   output logic          o_rvalid0,
   output logic [DW-1:0] o_rdata0,
   output logic          o_rvalid1,
   output logic [DW-1:0] o_rdata1
);

   rd_tag_t [RD_LAT-1:0] r_tag;
   rd_tag_t              w_head;

   // Tag shift register; the last stage lines up with valid RAM output data
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tag <= '0;
      end else begin
         r_tag[0] <= '{valid: i_push, port: i_port};
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   always_comb begin
      o_any_valid = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         o_any_valid = o_any_valid | r_tag[i].valid;
      end
   end

   assign w_head    = r_tag[RD_LAT-1];
   assign o_rvalid0 = tag_is_port(w_head, P_RENDER);
   assign o_rvalid1 = tag_is_port(w_head, P_LOGIC);
   assign o_rdata0  = o_rvalid0 ? i_ram_rdata : '0;
   assign o_rdata1  = o_rvalid1 ? i_ram_rdata : '0;

endmodule

// File: rtl/obj_ram_arbiter.sv
// Object RAM arbiter: the render port has fixed priority, the logic port is
// protected by a starvation guard; one RAM access per cycle, reads returned in order.
module obj_ram_arbiter
   import obj_ram_arbiter_pkg::*;
#(
   parameter int RD_LAT   = DEF_RD_LAT,
   parameter int MAX_WAIT = DEF_MAX_WAIT,
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_req0,
   input  logic [AW-1:0] i_addr0,
   input  logic          i_lock0,
   output logic          o_gnt0,
   output logic          o_rvalid0,
   output logic [DW-1:0] o_rdata0,
   input  logic          i_req1,
   input  logic          i_we1,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_wdata1,
   output logic          o_gnt1,
   output logic          o_rvalid1,
   output logic [DW-1:0] o_rdata1,
   output logic [AW-1:0] o_ram_address,
   output logic          o_ram_we,
   output logic [DW-1:0] o_ram_wdata,
   input  logic [DW-1:0] i_ram_rdata,
   output logic          o_busy
);

   localparam int            WW    = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
   localparam logic [WW-1:0] W_ONE = WW'(1);

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   logic [WW-1:0] r_wait;
   logic [WW-1:0] w_wait_nxt;
   logic [WW-1:0] r_beats;
   logic [WW-1:0] w_beats_nxt;
   logic          w_starve;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_push;
   logic          w_any_tag;
   logic [AW-1:0] r_ram_address;
   logic          r_ram_we;
   logic [DW-1:0] r_ram_wdata;

   // Grant selection and ownership; port 1 ownership is capped at MAX_WAIT beats
   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_state_nxt = r_state;
      w_beats_nxt = r_beats;
      w_starve    = i_req1 && (r_wait == W_MAX);
      case (r_state)
         ST_IDLE: begin
            if (i_req1 && (!i_req0 || w_starve)) begin
               w_gnt1      = 1'b1;
               w_beats_nxt = W_ONE;
               w_state_nxt = (W_ONE >= W_MAX) ? ST_IDLE : ST_OWN1;
            end else if (i_req0) begin
               w_gnt0      = 1'b1;
               w_state_nxt = i_lock0 ? ST_OWN0 : ST_IDLE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_OWN0: begin
            w_gnt1      = w_starve;
            w_gnt0      = i_req0 && !w_starve;
            w_state_nxt = (i_req0 && i_lock0) ? ST_OWN0 : ST_IDLE;
         end
         ST_OWN1: begin
            w_gnt1 = i_req1;
            if (!i_req1) begin
               w_state_nxt = ST_IDLE;
            end else if ((r_beats + W_ONE) >= W_MAX) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_beats_nxt = r_beats + W_ONE;
               w_state_nxt = ST_OWN1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Port 1 wait counter, saturating at MAX_WAIT
   always_comb begin
      w_wait_nxt = '0;
      if (i_req1 && !w_gnt1) begin
         if (r_wait == W_MAX) begin
            w_wait_nxt = W_MAX;
         end else begin
            w_wait_nxt = r_wait + W_ONE;
         end
      end else begin
         w_wait_nxt = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_wait  <= '0;
         r_beats <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
         r_beats <= w_beats_nxt;
      end
   end

   // RAM command register: address and write data hold between grants
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ram_address <= '0;
         r_ram_we      <= 1'b0;
         r_ram_wdata   <= '0;
      end else if (w_gnt1) begin
         r_ram_address <= i_addr1;
         r_ram_we      <= i_we1;
         r_ram_wdata   <= i_wdata1;
      end else if (w_gnt0) begin
         r_ram_address <= i_addr0;
         r_ram_we      <= 1'b0;
      end else begin
         r_ram_we      <= 1'b0;
      end
   end

   assign w_push = w_gnt0 || (w_gnt1 && !i_we1);

   obj_ram_arbiter_rd_tag_pipe #(
      .RD_LAT (RD_LAT),
      .DW     (DW)
   ) u_tag_pipe (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_port      (w_gnt1),
      .i_ram_rdata (i_ram_rdata),
      .o_any_valid (w_any_tag),
      .o_rvalid0   (o_rvalid0),
      .o_rdata0    (o_rdata0),
      .o_rvalid1   (o_rvalid1),
      .o_rdata1    (o_rdata1)
   );

   // Grants are combinational, so they are held off while reset is asserted
   assign o_gnt0        = w_gnt0 && !i_rst;
   assign o_gnt1        = w_gnt1 && !i_rst;
   assign o_ram_address = r_ram_address;
   assign o_ram_we      = r_ram_we;
   assign o_ram_wdata   = r_ram_wdata;
   assign o_busy        = (r_state != ST_IDLE) || w_any_tag;

endmodule

// File: tb/tb_obj_ram_arbiter.sv
// Self-checking bench: a queue-based arbitration model plus an in-bench RAM,
// directed scenarios with literal pins, then randomized traffic.
module tb_obj_ram_arbiter;
   import obj_ram_arbiter_pkg::*;

   localparam int AW = 5;
   localparam int DW = 8;
   localparam int RD_LAT = 2;
   localparam int MAX_WAIT = 8;

   typedef struct { logic [AW-1:0] addr; logic lock; } p0_item_t;
   typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } p1_item_t;
   typedef struct { int due; logic port; logic [DW-1:0] data; } rd_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata1 = '0;
   logic gnt0, rvalid0, gnt1, rvalid1, ram_we, busy;
   logic [DW-1:0] rdata0, rdata1, ram_wdata;
   logic [DW-1:0] ram_q;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram [32];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   p0_item_t q0[$];
   p1_item_t q1[$];
   rd_exp_t  pend[$];
   logic [DW-1:0] shadow [32];
   int m_owner = -1;
   int m_wait = 0;
   int m_beats = 0;
   logic [AW-1:0] m_addr = '0;
   logic m_we = 1'b0;
   logic [DW-1:0] m_wdata = '0;
   int got0[$], got1[$], g0_cyc[$], g1_cyc[$], rv0_cyc[$], rv1_cyc[$];
   int we_cnt = 0;

   always #5 clk = ~clk;

   obj_ram_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0), .i_addr0(addr0), .i_lock0(lock0),
      .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
      .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
      .o_ram_address(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_q), .o_busy(busy)
   );

   function automatic logic [DW-1:0] init_val(input int a);
      case (a)
         0: return 8'd1;
         1: return 8'd10;
         2: return 8'd20;
         3: return 8'd117;
         4: return 8'd15;
         5: return 8'd25;
         6: return 8'd50;
         7: return 8'd30;
         default: return 8'(a * 7 + 3);
      endcase
   endfunction

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -999;
   endfunction

   // Environment RAM: registered output, one cycle after the registered address
   initial begin
      for (int i = 0; i < 32; i++) ram[i] = init_val(i);
      ram_q = '0;
      forever begin
         @(posedge clk);
         ram_q <= ram[ram_addr];
         if (ram_we) ram[ram_addr] <= ram_wdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
      chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
      chk({tag, "_rvalid0"}, 32'(rvalid0), 32'd0);
      chk({tag, "_rvalid1"}, 32'(rvalid1), 32'd0);
      chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
      chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic model_reset();
      m_owner = -1; m_wait = 0; m_beats = 0;
      pend.delete();
      m_addr = '0; m_we = 1'b0; m_wdata = '0;
   endtask

   task automatic clear_rec();
      got0.delete(); got1.delete(); g0_cyc.delete(); g1_cyc.delete();
      rv0_cyc.delete(); rv1_cyc.delete(); we_cnt = 0;
   endtask

   task automatic drive();
      req0   = (q0.size() != 0);
      addr0  = req0 ? q0[0].addr : 5'd0;
      lock0  = req0 ? q0[0].lock : 1'b0;
      req1   = (q1.size() != 0);
      we1    = req1 ? q1[0].we : 1'b0;
      addr1  = req1 ? q1[0].addr : 5'd0;
      wdata1 = req1 ? q1[0].wdata : 8'd0;
   endtask

   // One cycle: drive at negedge, compare against the model, advance the model
   task automatic step();
      bit g0, g1, starve, hit;
      drive();
      #1;
      starve = req1 && (m_wait == MAX_WAIT);
      g0 = 1'b0; g1 = 1'b0;
      if (m_owner == 1) begin
         g1 = req1;
      end else if (m_owner == 0) begin
         g1 = starve;
         g0 = req0 && !starve;
      end else begin
         g1 = req1 && (!req0 || starve);
         g0 = req0 && !g1;
      end
      hit = (pend.size() != 0) && (pend[0].due == cyc);
      chk("gnt0", 32'(gnt0), 32'(g0));
      chk("gnt1", 32'(gnt1), 32'(g1));
      chk("rvalid0", 32'(rvalid0), 32'(hit && (pend[0].port == 1'b0)));
      chk("rvalid1", 32'(rvalid1), 32'(hit && (pend[0].port == 1'b1)));
      chk("busy", 32'(busy), 32'((m_owner != -1) || (pend.size() != 0)));
      chk("ram_we", 32'(ram_we), 32'(m_we));
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      if (m_we) chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
      if (hit) begin
         if (pend[0].port == 1'b0) begin
            chk("rdata0", 32'(rdata0), 32'(pend[0].data));
            got0.push_back(int'(rdata0)); rv0_cyc.push_back(cyc);
         end else begin
            chk("rdata1", 32'(rdata1), 32'(pend[0].data));
            got1.push_back(int'(rdata1)); rv1_cyc.push_back(cyc);
         end
         void'(pend.pop_front());
      end
      if (gnt0) g0_cyc.push_back(cyc);
      if (gnt1) g1_cyc.push_back(cyc);
      if (ram_we) we_cnt++;
      if (g0) begin
         pend.push_back('{due: cyc + RD_LAT, port: 1'b0, data: shadow[addr0]});
         m_addr = addr0; m_we = 1'b0;
      end else if (g1) begin
         m_addr = addr1; m_we = we1;
         if (we1) begin
            shadow[addr1] = wdata1; m_wdata = wdata1;
         end else begin
            pend.push_back('{due: cyc + RD_LAT, port: 1'b1, data: shadow[addr1]});
         end
      end else begin
         m_we = 1'b0;
      end
      m_wait = (req1 && !g1) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      if (m_owner == -1) begin
         if (g0 && lock0) m_owner = 0;
         else if (g1) begin m_owner = (MAX_WAIT > 1) ? 1 : -1; m_beats = 1; end
      end else if (m_owner == 0) begin
         if (!(req0 && lock0)) m_owner = -1;
      end else begin
         if (!req1) m_owner = -1;
         else begin m_beats++; if (m_beats >= MAX_WAIT) m_owner = -1; end
      end
      @(posedge clk);
      cyc++;
      if (g0) void'(q0.pop_front());
      if (g1) void'(q1.pop_front());
      @(negedge clk);
   endtask

   task automatic run_idle(input int limit);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || pend.size() != 0 || m_owner != -1) && n < limit) begin
         step();
         n++;
      end
      chk("drain_in_budget", 32'(n < limit), 32'd1);
      repeat (2) step();
   endtask

   initial begin
      int len;
      int rel;
      logic lk;
      for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
      req0 = 1'b1; req1 = 1'b1;
      #3;
      chk_zero("reset");
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Port 0 locked burst over the whole object map
      clear_rec();
      for (int i = 0; i < 8; i++) q0.push_back('{addr: 5'(i), lock: 1'b1});
      run_idle(40);
      chk("s1_nrd", 32'(got0.size()), 32'd8);
      chk("s1_d0", 32'(at(got0, 0)), 32'd1);
      chk("s1_d3", 32'(at(got0, 3)), 32'd117);
      chk("s1_d6", 32'(at(got0, 6)), 32'd50);
      chk("s1_d7", 32'(at(got0, 7)), 32'd30);
      chk("s1_span", 32'(at(g0_cyc, 7) - at(g0_cyc, 0)), 32'd7);
      chk("s1_lat", 32'(at(rv0_cyc, 0) - at(g0_cyc, 0)), 32'd2);

      // Port 1 write then read-back of the ball X position
      clear_rec();
      q1.push_back('{we: 1'b1, addr: BALL_X, wdata: 8'h33});
      q1.push_back('{we: 1'b0, addr: BALL_X, wdata: 8'h00});
      run_idle(40);
      chk("s2_ngnt", 32'(g1_cyc.size()), 32'd2);
      chk("s2_b2b", 32'(at(g1_cyc, 1) - at(g1_cyc, 0)), 32'd1);
      chk("s2_we_cnt", 32'(we_cnt), 32'd1);
      chk("s2_rd", 32'(at(got1, 0)), 32'h33);
      chk("s2_lat", 32'(at(rv1_cyc, 0) - at(g1_cyc, 1)), 32'd2);

      // Simultaneous unlocked requests
      clear_rec();
      q0.push_back('{addr: P2_X, lock: 1'b0});
      q1.push_back('{we: 1'b0, addr: P2_Y, wdata: 8'h00});
      run_idle(40);
      chk("s3_order", 32'(at(g1_cyc, 0) - at(g0_cyc, 0)), 32'd1);
      chk("s3_d0", 32'(at(got0, 0)), 32'd117);
      chk("s3_d1", 32'(at(got1, 0)), 32'd15);

      // Starvation guard inside a 20-beat locked burst
      clear_rec();
      for (int i = 0; i < 20; i++) q0.push_back('{addr: 5'(i % 8), lock: 1'b1});
      q1.push_back('{we: 1'b0, addr: BALL_Y, wdata: 8'h00});
      run_idle(80);
      chk("s4_ngnt1", 32'(g1_cyc.size()), 32'd1);
      chk("s4_wait", 32'(at(g1_cyc, 0) - at(g0_cyc, 0)), 32'd8);
      chk("s4_ngnt0", 32'(g0_cyc.size()), 32'd20);
      chk("s4_span", 32'(at(g0_cyc, 19) - at(g0_cyc, 0)), 32'd20);
      chk("s4_d1", 32'(at(got1, 0)), 32'd30);

      // Port 1 read issued right after a port 0 read
      clear_rec();
      q0.push_back('{addr: P1_Y, lock: 1'b0});
      step();
      q1.push_back('{we: 1'b0, addr: P1_H, wdata: 8'h00});
      run_idle(40);
      chk("s6_d0", 32'(at(got0, 0)), 32'd10);
      chk("s6_d1", 32'(at(got1, 0)), 32'd20);
      chk("s6_seq", 32'(at(rv1_cyc, 0) - at(rv0_cyc, 0)), 32'd1);

      // Reset with two reads in flight
      q0.push_back('{addr: P1_X, lock: 1'b0});
      q0.push_back('{addr: P2_H, lock: 1'b0});
      step();
      step();
      q1.push_back('{we: 1'b0, addr: BALL_X, wdata: 8'h00});
      rst = 1'b1;
      drive();
      #1;
      chk_zero("midrst");
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clear_rec();
      rel = cyc;
      run_idle(40);
      chk("s5_no_rv0", 32'(got0.size()), 32'd0);
      chk("s5_first_gnt", 32'(at(g1_cyc, 0) - rel), 32'd0);
      chk("s5_d1", 32'(at(got1, 0)), 32'h33);

      // Randomized mixed traffic
      for (int k = 0; k < 600; k++) begin
         if (q0.size() == 0 && $urandom_range(99) < 25) begin
            len = $urandom_range(6, 1);
            lk = 1'($urandom_range(1));
            for (int j = 0; j < len; j++) q0.push_back('{addr: 5'($urandom_range(31)), lock: lk});
         end
         if (q1.size() == 0 && $urandom_range(99) < 40) begin
            q1.push_back('{we: 1'($urandom_range(1)), addr: 5'($urandom_range(31)), wdata: 8'($urandom_range(255))});
         end
         step();
      end
      run_idle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
